serial_disp_rx: RTL and testbench

Receive-side counterpart of the board's serial display/LED shift-register drivers. Samples the four-wire serial stream (`seg_clk`, `seg_sout`, `SEG_PEN`, `seg_clrn`) in the system clock domain and rebuilds the parallel frame the driver intended to load. Presents the frame through a valid/ack handshake. Used for loopback self-test of the display path and as a capture port for a second board.

---
 rtl/serial_disp_rx.sv | 141 ++++++++++++++
 tb/tb_serial_disp_rx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_disp_rx.sv
// Serial display-chain receiver: samples seg_clk/seg_sout/seg_pen/seg_clrn in the clk domain and
// rebuilds the parallel frame behind a valid/ack handshake. Optional glitch filter: SERIAL_DISP_RX_GLITCH_FILTER_EN.
module serial_disp_rx #(
   parameter int FRAME_BITS = 64,
   parameter int CNT_W      = 7
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  seg_clk,
   input  logic                  seg_sout,
   input  logic                  seg_pen,
   input  logic                  seg_clrn,
   output logic [FRAME_BITS-1:0] frame_data,
   output logic                  frame_valid,
   input  logic                  frame_ack,
   output logic                  frame_err,
   output logic                  overrun
);

   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

   // Bit order in the synchronizer vectors: {clrn, pen, sout, clk}
   logic [3:0] sync1_q, sync2_q;
   logic       clk_prev_q, pen_prev_q;
   logic       clk_lvl, pen_lvl, sout_al, clrn_s;
   logic       clk_rise, pen_rise;

   state_t                  state_q, state_d;
   logic [FRAME_BITS-1:0]   shift_q, shift_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic [FRAME_BITS-1:0]   data_q, data_d;
   logic                    valid_q, valid_d;
   logic                    err_q, err_d;
   logic                    ovr_q, ovr_d;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= {seg_clrn, seg_pen, seg_sout, seg_clk};
         sync2_q <= sync1_q;
      end
   end

`ifdef SERIAL_DISP_RX_GLITCH_FILTER_EN
   logic [2:0] sync3_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) sync3_q <= '0;
      else       sync3_q <= sync2_q[2:0];
   end

   // A level is accepted only after two equal samples; otherwise the previous level is held.
   assign clk_lvl = (sync2_q[0] == sync3_q[0]) ? sync2_q[0] : clk_prev_q;
   assign pen_lvl = (sync2_q[2] == sync3_q[2]) ? sync2_q[2] : pen_prev_q;
   assign sout_al = sync3_q[1];
`else
   assign clk_lvl = sync2_q[0];
   assign pen_lvl = sync2_q[2];
   assign sout_al = sync2_q[1];
`endif

   assign clrn_s   = sync2_q[3];
   assign clk_rise = clk_lvl & ~clk_prev_q;
   assign pen_rise = pen_lvl & ~pen_prev_q;

   // NOTE: every signal written here gets a default first, so no latches are inferred.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      count_d = count_q;
      data_d  = data_q;
      valid_d = valid_q;
      err_d   = err_q;
      ovr_d   = ovr_q;

      if (frame_ack && valid_q) valid_d = 1'b0;

      if (!clrn_s) begin
         state_d = IDLE;
         shift_d = '0;
         count_d = '0;
      end else begin
         unique case (state_q)
            IDLE, SHIFT: begin
               if (clk_rise) begin
                  shift_d = {shift_q[FRAME_BITS-2:0], sout_al};
                  count_d = (count_q == CNT_SAT) ? count_q : count_q + 1'b1;
                  state_d = SHIFT;
               end
               // The pen edge wins the state, but a coincident bit still lands in shift_d first.
               if (pen_rise) state_d = COMMIT;
            end
            COMMIT: begin
               data_d  = shift_q;
               err_d   = (count_q != CNT_FULL);
               valid_d = 1'b1;
               if (valid_q && !frame_ack) ovr_d = 1'b1;
               count_d = '0;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         clk_prev_q <= 1'b0;
         pen_prev_q <= 1'b0;
         state_q    <= IDLE;
         shift_q    <= '0;
         count_q    <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         clk_prev_q <= clk_lvl;
         pen_prev_q <= pen_lvl;
         state_q    <= state_d;
         shift_q    <= shift_d;
         count_q    <= count_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
         ovr_q      <= ovr_d;
      end
   end

   assign frame_data  = data_q;
   assign frame_valid = valid_q;
   assign frame_err   = err_q;
   assign overrun     = ovr_q;

endmodule

// File: tb/tb_serial_disp_rx.sv
// Directed bench for serial_disp_rx (64-bit frame); expectations follow SERIAL_DISP_RX_GLITCH_FILTER_EN if defined.
module tb_serial_disp_rx;

`ifdef SERIAL_DISP_RX_GLITCH_FILTER_EN
   localparam int  LAT      = 5;
   localparam bit  FILTERED = 1'b1;
`else
   localparam int  LAT      = 4;
   localparam bit  FILTERED = 1'b0;
`endif
   localparam int PH = 4;

   logic        clk = 1'b0;
   logic        rstn;
   logic        seg_clk, seg_sout, seg_pen, seg_clrn;
   logic [63:0] frame_data;
   logic        frame_valid, frame_ack, frame_err, overrun;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   serial_disp_rx #(.FRAME_BITS(64), .CNT_W(7)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .seg_clk     (seg_clk),
      .seg_sout    (seg_sout),
      .seg_pen     (seg_pen),
      .seg_clrn    (seg_clrn),
      .frame_data  (frame_data),
      .frame_valid (frame_valid),
      .frame_ack   (frame_ack),
      .frame_err   (frame_err),
      .overrun     (overrun)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Advance n clock edges and settle 1 ns past the last one.
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input bit glitch);
      seg_sout = b;
      if (glitch) begin
         cyc(2);
         seg_clk = 1'b1;
         cyc(1);
         seg_clk = 1'b0;
         cyc(2);
      end else begin
         cyc(PH + 1);
      end
      seg_clk = 1'b1;
      cyc(PH);
      seg_clk = 1'b0;
   endtask

   // MSB first: w[n-1] goes out first.
   task automatic send_word(input logic [63:0] w, input int n, input bit glitch);
      for (int i = n - 1; i >= 0; i--) send_bit(w[i], glitch && (i % 8 == 3));
      cyc(2);
   endtask

   task automatic pen_pulse(input bit ack_at_commit);
      seg_pen = 1'b1;
      cyc(LAT - 1);
      frame_ack = ack_at_commit;
      cyc(1);
      frame_ack = 1'b0;
      cyc(1);
      seg_pen = 1'b0;
      cyc(4);
   endtask

   task automatic do_ack();
      frame_ack = 1'b1;
      cyc(1);
      frame_ack = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_data"},  frame_data,  64'h0);
      check({tag, "_valid"}, frame_valid, 1'b0);
      check({tag, "_err"},   frame_err,   1'b0);
      check({tag, "_ovr"},   overrun,     1'b0);
   endtask

   initial begin
      rstn = 1'b0; seg_clk = 1'b0; seg_sout = 1'b0; seg_pen = 1'b0;
      seg_clrn = 1'b1; frame_ack = 1'b0;
      cyc(3);
      check_all_zero("reset");
      rstn = 1'b1;
      cyc(4);

      // Full frame with latency check around the pen edge.
      send_word(64'hDEAD_BEEF_0123_4567, 64, 1'b0);
      seg_pen = 1'b1;
      cyc(LAT - 1);
      check("lat_pre_valid", frame_valid, 1'b0);
      cyc(1);
      check("lat_valid", frame_valid, 1'b1);
      check("a_data", frame_data, 64'hDEAD_BEEF_0123_4567);
      check("a_err", frame_err, 1'b0);
      check("a_ovr", overrun, 1'b0);
      cyc(1);
      seg_pen = 1'b0;
      cyc(4);
      do_ack();
      check("a_ack_valid", frame_valid, 1'b0);

      // Short frame: the retained bit 0 of the previous frame ends up in bit 63.
      send_word(64'h0, 63, 1'b0);
      pen_pulse(1'b0);
      check("short_err", frame_err, 1'b1);
      check("short_data", frame_data, 64'h8000_0000_0000_0000);
      do_ack();

      // Long frame: 70 bits, last 64 retained.
      send_word(64'h2A, 6, 1'b0);
      send_word(64'h0123_4567_89AB_CDEF, 64, 1'b0);
      pen_pulse(1'b0);
      check("long_err", frame_err, 1'b1);
      check("long_data", frame_data, 64'h0123_4567_89AB_CDEF);
      do_ack();

      // Two frames without ack.
      send_word(64'h1111_1111_1111_1111, 64, 1'b0);
      pen_pulse(1'b0);
      check("ovr1_ovr", overrun, 1'b0);
      send_word(64'h2222_2222_2222_2222, 64, 1'b0);
      pen_pulse(1'b0);
      check("ovr2_data", frame_data, 64'h2222_2222_2222_2222);
      check("ovr2_valid", frame_valid, 1'b1);
      check("ovr2_ovr", overrun, 1'b1);
      do_ack();
      check("ovr_ack_valid", frame_valid, 1'b0);
      check("ovr_sticky", overrun, 1'b1);

      rstn = 1'b0;
      cyc(2);
      check_all_zero("rst2");
      rstn = 1'b1;
      cyc(4);

      // Chain clear mid-frame discards the partial bits and count.
      send_word(64'h3FFF_FFFF, 30, 1'b0);
      seg_clrn = 1'b0;
      cyc(4);
      seg_clrn = 1'b1;
      cyc(4);
      send_word(64'hFFFF_0000_FFFF_0000, 64, 1'b0);
      pen_pulse(1'b0);
      check("clr_data", frame_data, 64'hFFFF_0000_FFFF_0000);
      check("clr_err", frame_err, 1'b0);
      check("clr_valid", frame_valid, 1'b1);

      // Commit and ack on the same edge while a frame is pending.
      send_word(64'hA5A5_A5A5_A5A5_A5A5, 64, 1'b0);
      pen_pulse(1'b1);
      check("cack_valid", frame_valid, 1'b1);
      check("cack_data", frame_data, 64'hA5A5_A5A5_A5A5_A5A5);
      check("cack_ovr", overrun, 1'b0);

      // Asynchronous reset mid-shift clears outputs without a clock edge.
      send_word(64'hFFFFF, 20, 1'b0);
      rstn = 1'b0;
      #1;
      check_all_zero("midrst");
      cyc(2);
      rstn = 1'b1;
      cyc(4);
      send_word(64'h0F0F_1234_5678_9ABC, 64, 1'b0);
      pen_pulse(1'b0);
      check("post_rst_data", frame_data, 64'h0F0F_1234_5678_9ABC);
      check("post_rst_err", frame_err, 1'b0);
      do_ack();

      // Single-cycle seg_clk glitches on eight of the bits.
      send_word(64'hC3C3_5A5A_9696_0FF0, 64, 1'b1);
      pen_pulse(1'b0);
      if (FILTERED) begin
         check("glitch_data", frame_data, 64'hC3C3_5A5A_9696_0FF0);
         check("glitch_err", frame_err, 1'b0);
      end else begin
         check("glitch_err", frame_err, 1'b1);
      end
      check("glitch_valid", frame_valid, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
